// File: rtl/mdio_pkg.sv
// mdio_pkg: shared definitions for the Clause-22 MDIO frame controller.
//   - state_t: frame decoder FSM states
//   - OP/TA codes as they appear in the shift window (older bit in [1])
//   - default preamble length and per-field bit counts
//   - field_done(): true on the last bit of a field
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_DATA
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] TA_WRITE = 2'b10;

  localparam int PRE_LEN_DEF = 32;
  localparam int OP_LEN      = 2;
  localparam int PHYAD_LEN   = 5;
  localparam int REGAD_LEN   = 5;
  localparam int TA_LEN      = 2;
  localparam int DATA_LEN    = 16;

  // bit_cnt counts from 0, so the field ends when it reaches len-1.
  function automatic logic field_done(input logic [3:0] cnt, input int len);
    return cnt == 4'(len - 1);
  endfunction

endpackage

// File: rtl/mdio_preamble_det.sv
// mdio_preamble_det: counts consecutive preamble ones on the MDIO line.
//   clk, rstn    : clock, asynchronous active-low reset
//   soft_reset   : synchronous reset, same effect as rstn
//   bit_valid    : a new bit is present and the decoder is in IDLE
//   bit_in       : the new MDIO bit
//   clear        : decoder is inside a frame; hold the count at zero
//   pre_ok       : a 0 now would be accepted as the first ST bit
// Build option: MDIO_PREAMBLE_SUPPRESS_EN relaxes pre_ok to "at least one 1",
// so frames separated by a single idle bit are accepted.
module mdio_preamble_det #(
  parameter int PRE_LEN = 32
) (
  input  logic clk,
  input  logic rstn,
  input  logic soft_reset,
  input  logic bit_valid,
  input  logic bit_in,
  input  logic clear,
  output logic pre_ok
);

  logic [5:0] ones_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ones_cnt <= '0;
    end else if (soft_reset || clear) begin
      ones_cnt <= '0;
    end else if (bit_valid) begin
      if (!bit_in)
        ones_cnt <= '0;
      else if (ones_cnt != 6'(PRE_LEN))
        ones_cnt <= ones_cnt + 6'd1;  // saturates at PRE_LEN
    end
  end

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign pre_ok = (ones_cnt != 6'd0);
`else
  assign pre_ok = (ones_cnt == 6'(PRE_LEN));
`endif

endmodule

// File: rtl/mdio_frame_ctrl.sv
// mdio_frame_ctrl: Clause-22 MDIO frame decoder for the PHY-side slave.
//   clk, rstn         : clock, asynchronous active-low reset
//   soft_reset        : synchronous reset, same effect as rstn; aborts a frame
//   shift_reg_window  : datapath window, bit0 = newest MDIO bit
//   update_stage      : one-clk strobe, window holds a new bit
//   phy_addr          : this PHY's address
//   data_phase        : high during the 16 data bits
//   is_write          : OP of current frame was write
//   mdio_out_cnt      : data bit index 0..15
//   mdio_txd          : read data held for the datapath
//   mdio_oe           : pad output enable (read data phase)
//   reg_addr          : captured REGAD
//   reg_rd / reg_rdata: one-clk read strobe / data valid the clk after
//   reg_wr / reg_wdata: one-clk write strobe / data valid with it
//   frame_err         : one-clk pulse on an aborted frame
// Build option: MDIO_PREAMBLE_SUPPRESS_EN (see mdio_preamble_det).
module mdio_frame_ctrl
  import mdio_pkg::*;
#(
  parameter int PRE_LEN = PRE_LEN_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        soft_reset,
  input  logic [15:0] shift_reg_window,
  input  logic        update_stage,
  input  logic [4:0]  phy_addr,
  output logic        data_phase,
  output logic        is_write,
  output logic [3:0]  mdio_out_cnt,
  output logic [15:0] mdio_txd,
  output logic        mdio_oe,
  output logic [4:0]  reg_addr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        reg_wr,
  output logic [15:0] reg_wdata,
  output logic        frame_err
);

  state_t     state;
  logic [3:0] bit_cnt;
  logic       rd_pend;   // reg_rd was high last clk: reg_rdata is valid now
  logic       pre_ok;
  logic       b;

  assign b = shift_reg_window[0];

  mdio_preamble_det #(.PRE_LEN(PRE_LEN)) u_pre (
    .clk        (clk),
    .rstn       (rstn),
    .soft_reset (soft_reset),
    .bit_valid  (update_stage && (state == S_IDLE)),
    .bit_in     (b),
    .clear      (state != S_IDLE),
    .pre_ok     (pre_ok)
  );

  assign mdio_oe = data_phase & ~is_write;

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch below sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      bit_cnt      <= '0;
      rd_pend      <= 1'b0;
      data_phase   <= 1'b0;
      is_write     <= 1'b0;
      mdio_out_cnt <= '0;
      mdio_txd     <= '0;
      reg_addr     <= '0;
      reg_rd       <= 1'b0;
      reg_wr       <= 1'b0;
      reg_wdata    <= '0;
      frame_err    <= 1'b0;
    end else if (soft_reset) begin
      // Abort silently: no pending write and no error pulse survive.
      state        <= S_IDLE;
      bit_cnt      <= '0;
      rd_pend      <= 1'b0;
      data_phase   <= 1'b0;
      is_write     <= 1'b0;
      mdio_out_cnt <= '0;
      mdio_txd     <= '0;
      reg_addr     <= '0;
      reg_rd       <= 1'b0;
      reg_wr       <= 1'b0;
      reg_wdata    <= '0;
      frame_err    <= 1'b0;
    end else begin
      reg_rd    <= 1'b0;
      reg_wr    <= 1'b0;
      frame_err <= 1'b0;
      rd_pend   <= reg_rd;
      if (rd_pend)
        mdio_txd <= reg_rdata;

      if (update_stage) begin
        case (state)
          S_IDLE: begin
            // This 0 is the first ST bit.
            if (!b && pre_ok) begin
              state   <= S_ST;
              bit_cnt <= '0;
            end
          end

          S_ST: begin
            if (b) begin
              state <= S_OP;
            end else begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
            end
            bit_cnt <= '0;
          end

          S_OP: begin
            if (field_done(bit_cnt, OP_LEN)) begin
              bit_cnt <= '0;
              case (shift_reg_window[1:0])
                OP_WRITE: begin
                  is_write <= 1'b1;
                  state    <= S_PHYAD;
                end
                OP_READ: begin
                  is_write <= 1'b0;
                  state    <= S_PHYAD;
                end
                default: begin
                  frame_err <= 1'b1;
                  state     <= S_IDLE;
                end
              endcase
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end

          S_PHYAD: begin
            if (field_done(bit_cnt, PHYAD_LEN)) begin
              bit_cnt <= '0;
              // Frames for other PHYs are not errors; just stop listening.
              state   <= (shift_reg_window[4:0] == phy_addr) ? S_REGAD : S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end

          S_REGAD: begin
            if (field_done(bit_cnt, REGAD_LEN)) begin
              bit_cnt  <= '0;
              reg_addr <= shift_reg_window[4:0];
              // Issued here so the read data is in mdio_txd well before TA ends.
              reg_rd   <= ~is_write;
              state    <= S_TA;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end

          S_TA: begin
            if (field_done(bit_cnt, TA_LEN)) begin
              bit_cnt <= '0;
              if (is_write && (shift_reg_window[1:0] != TA_WRITE)) begin
                frame_err <= 1'b1;
                state     <= S_IDLE;
              end else begin
                data_phase   <= 1'b1;
                mdio_out_cnt <= '0;
                state        <= S_DATA;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end

          S_DATA: begin
            if (field_done(bit_cnt, DATA_LEN)) begin
              bit_cnt      <= '0;
              data_phase   <= 1'b0;
              mdio_out_cnt <= '0;
              state        <= S_IDLE;
              if (is_write) begin
                reg_wdata <= shift_reg_window;
                reg_wr    <= 1'b1;
              end
            end else begin
              bit_cnt      <= bit_cnt + 4'd1;
              mdio_out_cnt <= mdio_out_cnt + 4'd1;
            end
          end

          default: begin
            state   <= S_IDLE;
            bit_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_frame_ctrl.sv
// Directed bench for mdio_frame_ctrl: write, read, short preamble, foreign
// PHYAD, bad OP, bad write TA, soft_reset mid-frame.
module tb_mdio_frame_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        soft_reset;
  logic [15:0] shift_reg_window;
  logic        update_stage;
  logic [4:0]  phy_addr;
  logic        data_phase;
  logic        is_write;
  logic [3:0]  mdio_out_cnt;
  logic [15:0] mdio_txd;
  logic        mdio_oe;
  logic [4:0]  reg_addr;
  logic        reg_rd;
  logic [15:0] reg_rdata;
  logic        reg_wr;
  logic [15:0] reg_wdata;
  logic        frame_err;

  mdio_frame_ctrl dut (
    .clk              (clk),
    .rstn             (rstn),
    .soft_reset       (soft_reset),
    .shift_reg_window (shift_reg_window),
    .update_stage     (update_stage),
    .phy_addr         (phy_addr),
    .data_phase       (data_phase),
    .is_write         (is_write),
    .mdio_out_cnt     (mdio_out_cnt),
    .mdio_txd         (mdio_txd),
    .mdio_oe          (mdio_oe),
    .reg_addr         (reg_addr),
    .reg_rd           (reg_rd),
    .reg_rdata        (reg_rdata),
    .reg_wr           (reg_wr),
    .reg_wdata        (reg_wdata),
    .frame_err        (frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Register-file model: data valid the clk after reg_rd, garbage otherwise.
  logic [15:0] rf_value = 16'h0000;
  always @(posedge clk) reg_rdata <= reg_rd ? rf_value : 16'hDEAD;

  // Strobe monitors (cumulative; the stimulus takes differences).
  int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0, dp_cnt = 0;
  logic [4:0]  wr_addr_q = '0;
  logic [15:0] wr_data_q = '0;
  always @(posedge clk) begin
    if (reg_wr) begin
      wr_cnt    <= wr_cnt + 1;
      wr_addr_q <= reg_addr;
      wr_data_q <= reg_wdata;
    end
    if (reg_rd)                      rd_cnt  <= rd_cnt + 1;
    if (frame_err)                   err_cnt <= err_cnt + 1;
    if (update_stage && data_phase)  dp_cnt  <= dp_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] win = '0;

  // One MDC period: new bit + one-clk strobe, then idle clocks.
  task automatic send_bit(input logic b);
    @(negedge clk);
    win              = {win[14:0], b};
    shift_reg_window = win;
    update_stage     = 1'b1;
    @(negedge clk);
    update_stage = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_field(input logic [15:0] v, input int len);
    for (int i = len - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_header(input int pre, input logic [1:0] op,
                             input logic [4:0] pa, input logic [4:0] ra);
    repeat (pre) send_bit(1'b1);
    send_field(16'h0001, 2);
    send_field({14'b0, op}, 2);
    send_field({11'b0, pa}, 5);
    send_field({11'b0, ra}, 5);
  endtask

  // Sends 16 data bits; verifies data_phase/out_cnt/oe before each bit
  // and their idle values after the last one.
  task automatic send_data(input logic [15:0] d, input logic exp_oe, output logic ok);
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (data_phase !== 1'b1 || mdio_out_cnt !== 4'(i) || mdio_oe !== exp_oe) ok = 1'b0;
      send_bit(d[15 - i]);
    end
    if (data_phase !== 1'b0 || mdio_out_cnt !== 4'd0 || mdio_oe !== 1'b0) ok = 1'b0;
  endtask

  int   w0, r0, e0, d0;
  logic ok;

  task automatic snap();
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; d0 = dp_cnt;
  endtask

  initial begin
    rstn             = 1'b0;
    soft_reset       = 1'b0;
    update_stage     = 1'b0;
    shift_reg_window = '0;
    phy_addr         = 5'h03;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {data_phase, is_write, mdio_out_cnt, mdio_txd, mdio_oe, reg_addr,
           reg_rd, reg_wr, reg_wdata, frame_err}, 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0xA5C3 to reg 0x0A.
    snap();
    send_header(32, 2'b01, 5'h03, 5'h0A);
    send_field(16'h0002, 2);
    send_data(16'hA5C3, 1'b0, ok);
    check("wr_seq",       ok, 1);
    check("wr_strobes",   wr_cnt - w0, 1);
    check("wr_addr",      wr_addr_q, 5'h0A);
    check("wr_data",      wr_data_q, 16'hA5C3);
    check("wr_dp_len",    dp_cnt - d0, 16);
    check("wr_no_rd_err", (rd_cnt - r0) + (err_cnt - e0), 0);
    check("wr_is_write",  is_write, 1);
    check("wr_hold",      {reg_addr, reg_wdata}, {5'h0A, 16'hA5C3});

    // Read reg 0x02 -> 0x1234.
    rf_value = 16'h1234;
    snap();
    send_header(32, 2'b10, 5'h03, 5'h02);
    send_bit(1'b0);
    check("rd_oe_ta",     mdio_oe, 0);
    send_bit(1'b0);
    send_data(16'h1234, 1'b1, ok);
    check("rd_seq",       ok, 1);
    check("rd_strobes",   rd_cnt - r0, 1);
    check("rd_txd",       mdio_txd, 16'h1234);
    check("rd_addr",      reg_addr, 5'h02);
    check("rd_is_write",  is_write, 0);
    check("rd_no_wr",     wr_cnt - w0, 0);
    check("rd_wdata_hold", reg_wdata, 16'hA5C3);

    // 31-bit preamble.
    snap();
    send_header(31, 2'b01, 5'h03, 5'h0C);
    send_field(16'h0002, 2);
    send_field(16'h5A5A, 16);
    repeat (3) @(negedge clk);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    check("short_pre_wr", wr_cnt - w0, 1);
    check("short_pre_data", wr_data_q, 16'h5A5A);
`else
    check("short_pre_wr", wr_cnt - w0, 0);
    check("short_pre_dp", dp_cnt - d0, 0);
`endif
    check("short_pre_err", err_cnt - e0, 0);

    // Foreign PHYAD: silent drop, then a good frame.
    snap();
    send_header(32, 2'b01, 5'h04, 5'h0A);
    repeat (3) @(negedge clk);
    check("phy_miss_quiet", (wr_cnt - w0) + (rd_cnt - r0) + (err_cnt - e0), 0);
    check("phy_miss_dp",  data_phase, 0);
    snap();
    send_header(32, 2'b01, 5'h03, 5'h05);
    send_field(16'h0002, 2);
    send_data(16'h0F0F, 1'b0, ok);
    check("after_miss_wr", {wr_cnt - w0, 11'b0, wr_addr_q, wr_data_q}, {32'd1, 11'b0, 5'h05, 16'h0F0F});

    // OP = 11.
    snap();
    repeat (32) send_bit(1'b1);
    send_field(16'h0001, 2);
    send_field(16'h0003, 2);
    repeat (2) @(negedge clk);
    check("op11_err",     err_cnt - e0, 1);

    // Write with TA = 11.
    snap();
    send_header(32, 2'b01, 5'h03, 5'h0A);
    send_field(16'h0003, 2);
    repeat (2) @(negedge clk);
    check("ta11_err",     err_cnt - e0, 1);
    check("ta11_no_wr",   wr_cnt - w0, 0);
    check("ta11_dp",      data_phase, 0);

    // FSM back in IDLE: a read of reg 0x11 works.
    rf_value = 16'hBEEF;
    snap();
    send_header(32, 2'b10, 5'h03, 5'h11);
    send_field(16'h0000, 2);
    send_data(16'h0000, 1'b1, ok);
    check("after_err_rd", {rd_cnt - r0, mdio_txd}, {32'd1, 16'hBEEF});

    // soft_reset at data bit 8 of a write.
    snap();
    send_header(32, 2'b01, 5'h03, 5'h1F);
    send_field(16'h0002, 2);
    send_field(16'h00FF, 8);
    check("sr_mid_cnt",   {data_phase, mdio_out_cnt}, {1'b1, 4'd8});
    @(negedge clk);
    soft_reset = 1'b1;
    @(negedge clk);
    soft_reset = 1'b0;
    check("sr_outputs",
          {data_phase, is_write, mdio_out_cnt, mdio_txd, mdio_oe, reg_addr,
           reg_rd, reg_wr, reg_wdata, frame_err}, 64'd0);
    repeat (5) @(negedge clk);
    check("sr_no_wr_err", (wr_cnt - w0) + (err_cnt - e0), 0);
    snap();
    send_header(32, 2'b01, 5'h03, 5'h07);
    send_field(16'h0002, 2);
    send_data(16'h3C3C, 1'b0, ok);
    check("after_sr_wr",  {wr_cnt - w0, 11'b0, wr_addr_q, wr_data_q}, {32'd1, 11'b0, 5'h07, 16'h3C3C});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdio_frame_ctrl.md
# mdio_frame_ctrl

Clause-22 MDIO frame controller for the PHY-side management slave. Sits directly downstream of the MDIO datapath, consuming its `shift_reg_window` and `update_stage` strobe, and produces what the datapath needs back (`data_phase`, `is_write`, `mdio_out_cnt`, `mdio_txd`). Decodes preamble, ST, OP, PHYAD, REGAD, TA and data, and issues single-cycle read and write strobes to the management register file.

## Interface
- PRE_LEN, 32: consecutive 1 bits required as preamble.
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- soft_reset  in  1  synchronous reset, same effect as rstn.
- shift_reg_window  in  16  datapath window; bit0 is the newest MDIO bit.
- update_stage  in  1  one-clk strobe; the window holds a new bit this cycle.
- phy_addr  in  5  this PHY's address (static).
- data_phase  out  1  high during the 16 data bits.
- is_write  out  1  OP of the current frame was 01.
- mdio_out_cnt  out  4  data-bit index 0..15.
- mdio_txd  out  16  read data held for the datapath.
- mdio_oe  out  1  data_phase & ~is_write; MDIO pad output enable.
- reg_addr  out  5  captured REGAD.
- reg_rd  out  1  one-clk read strobe.
- reg_rdata  in  16  register-file read data, valid the clk after reg_rd.
- reg_wr  out  1  one-clk write strobe.
- reg_wdata  out  16  write data, valid with reg_wr.
- frame_err  out  1  one-clk pulse on an aborted frame.

## Operation
- Bit processing:
  - All decoding happens only in cycles where update_stage=1; bit b = shift_reg_window[0].
  - bit_cnt[3:0] counts bits within a field.
- FSM states: IDLE, ST, OP, PHYAD, REGAD, TA, DATA.
- IDLE:
  - b=1: ones_cnt increments, saturating at PRE_LEN (6-bit counter).
  - b=0 with ones_cnt==PRE_LEN: go to ST. This 0 is ST bit 1.
  - b=0 otherwise: ones_cnt←0.
- ST:
  - b=1: go to OP.
  - b=0: frame_err, go to IDLE.
- OP:
  - Takes 2 bits.
  - window[1:0]=01: is_write←1. window[1:0]=10: is_write←0.
  - 00 or 11: frame_err, go to IDLE.
- PHYAD:
  - Takes 5 bits; compare window[4:0] with phy_addr.
  - Mismatch: go to IDLE silently, no frame_err.
- REGAD:
  - Takes 5 bits; reg_addr←window[4:0].
  - If read: pulse reg_rd in the same cycle; mdio_txd←reg_rdata on the next clk.
- TA:
  - Takes 2 bits.
  - Write frame: requires 1 then 0; otherwise frame_err and go to IDLE.
  - Read frame: TA bits are ignored.
  - On the 2nd TA bit: data_phase←1, mdio_out_cnt←0.
- DATA:
  - Takes 16 bits; mdio_out_cnt increments on each of the first 15 strobes.
  - On the 16th strobe: data_phase←0, mdio_out_cnt←0, go to IDLE.
  - Write frame: on the 16th strobe, reg_wdata←window, with reg_wr pulsing one clk later.
- On every return to IDLE, ones_cnt←0.
- Reset values (rstn low or soft_reset high): state IDLE, ones_cnt 0, bit_cnt 0. Every output is 0 except reg_wdata/mdio_txd, which are 0x0000.
- soft_reset mid-frame aborts the frame: no reg_wr, no frame_err.
- A register write happens only if the full 16 data bits completed.

## Timing
- Field decisions: taken in the update_stage cycle itself.
- data_phase and is_write: registered. They change ≥2 clk before the next MDC rising edge, as long as MDC high/low time is ≥4 clk. The datapath's write-shift therefore sees data_phase for data bit 1.
- Read path: reg_rd is asserted 2 MDC periods (TA) before the first data bit; mdio_txd is stable 1 clk after reg_rd.
- Write path: reg_wr occurs 1 clk after the final data update_stage; reg_addr and reg_wdata are held until the next frame's REGAD.

## Configuration
- MDIO_PREAMBLE_SUPPRESS_EN defined: in IDLE, b=0 with ones_cnt≥1 starts ST. This accepts back-to-back frames separated by one idle bit.
- Undefined: the full PRE_LEN ones are required.

## Structure
- Package mdio_pkg holds: FSM state enum, OP_WRITE=2'b01, OP_READ=2'b10, TA_WRITE=2'b10, PRE_LEN default, field lengths (5, 5, 2, 16).
- Sub-module mdio_preamble_det: holds ones_cnt and the saturation/compare logic, and outputs pre_ok. Everything else is flat.

## Test plan
- Write frame: 32×1, 01, 01, PHYAD=phy_addr=5'h03, REGAD=5'h0A, TA 10, data 0xA5C3 -> one reg_wr with reg_addr=0x0A and reg_wdata=0xA5C3. data_phase is high for exactly 16 strobes.
- Read frame: reg 0x02, with reg_rdata=0x1234 -> reg_rd once; mdio_txd=0x1234; mdio_out_cnt runs 0..15; mdio_oe high only during DATA.
- 31-bit preamble, then a valid frame -> no strobes. The same with MDIO_PREAMBLE_SUPPRESS_EN -> frame accepted.
- PHYAD=5'h04 with phy_addr=5'h03 -> no reg_rd/reg_wr, no frame_err. The next valid frame is accepted.
- OP=11, and separately write TA=11 -> frame_err pulse, FSM returns to IDLE, no reg_wr.
- soft_reset asserted at data bit 8 of a write -> no reg_wr; all outputs at reset values next clk. The following valid frame succeeds.
